// File: rtl/fp_iter_cmult_pkg.sv
// Shared definitions for the iterative fixed-point complex multiplier:
// operand-conjugation mode encodings and the engine state encoding.
package fp_iter_cmult_pkg;

   localparam logic [1:0] CMULT_MODE_MUL    = 2'd0;
   localparam logic [1:0] CMULT_MODE_CONJ_B = 2'd1;
   localparam logic [1:0] CMULT_MODE_CONJ_A = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      S0,
      S1,
      S2,
      HOLD
   } cmult_state_e;

endpackage

// File: rtl/fp_iter_cmult_mul_unit.sv
// Serial shift-add signed multiplier: one multiplier bit per cycle.
// The start cycle's edge already folds in bit 0, so done pulses exactly n
// cycles after start. The fixed-point product stays on p until the next start.
module fp_iter_cmult_mul_unit #(
   parameter int n = 32,
   parameter int d = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic         done,
   output logic [n-1:0] p
);

   localparam int CW = $clog2(n) + 1;

   logic signed [2*n-1:0] acc;
   logic signed [2*n-1:0] mcand;
   logic signed [2*n-1:0] a_ext;
   logic        [n-1:0]   mplier;
   logic        [CW-1:0]  cnt;
   logic                  busy;

   assign a_ext = {{n{a[n-1]}}, a};
   assign p     = acc[n+d-1:d];

   // Control: iteration counter, busy flag and the one-cycle done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= 1'b0;
         done <= 1'b0;
         cnt  <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(1);
         end else if (busy) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(n - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   // Datapath: add the shifted multiplicand per set bit; the sign bit of the
   // two's-complement multiplier carries negative weight, so it subtracts.
   always_ff @(posedge clk) begin
      if (start) begin
         acc    <= b[0] ? a_ext : '0;
         mcand  <= a_ext <<< 1;
         mplier <= b >> 1;
      end else if (busy) begin
         if (mplier[0]) begin
            if (cnt == CW'(n - 1)) acc <= acc - mcand;
            else                   acc <= acc + mcand;
         end
         mcand  <= mcand <<< 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: rtl/fp_iter_cmult_buffered.sv
// Iterative fixed-point complex multiplier with a one-entry result buffer.
// Gauss 3-product schedule on one shared serial multiplier:
//   p0 = (ar+ac)(br+bc), p1 = ar*br, p2 = ac*bc
//   cr = p1 - p2,  cc = p0 - p1 - p2
// Conjugation is applied once, by negating ac or bc at accept time.
module fp_iter_cmult_buffered
   import fp_iter_cmult_pkg::*;
#(
   parameter int n = 32,
   parameter int d = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         recv_val,
   output logic         recv_rdy,
   input  logic [1:0]   mode,
   input  logic [n-1:0] ar,
   input  logic [n-1:0] ac,
   input  logic [n-1:0] br,
   input  logic [n-1:0] bc,
   output logic         send_val,
   input  logic         send_rdy,
   output logic [n-1:0] cr,
   output logic [n-1:0] cc
);

   cmult_state_e state, state_nxt;

   logic signed [n-1:0] ar_r, ac_r, br_r, bc_r;
   logic signed [n-1:0] ac_in, bc_in;
   logic signed [n-1:0] p0_r, p1_r;
   logic signed [n-1:0] cr_nxt, cc_nxt;
   logic        [n-1:0] mul_a, mul_b, mul_p;
   logic                mul_start, mul_done;
   logic                accept, buf_wr, buf_full;

   assign accept   = recv_val && (state == IDLE);
   assign send_val = buf_full;
   assign cr_nxt   = p1_r - $signed(mul_p);
   assign cc_nxt   = p0_r - p1_r - $signed(mul_p);

   // Conjugation by negation of one imaginary input; mode 3 behaves as mode 0.
   always_comb begin
      ac_in = $signed(ac);
      bc_in = $signed(bc);
      if (mode == CMULT_MODE_CONJ_B)      bc_in = -$signed(bc);
      else if (mode == CMULT_MODE_CONJ_A) ac_in = -$signed(ac);
   end

   // Engine state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state, multiplier sequencing and handshake outputs. The S0 product
   // starts on the accept cycle straight from the ports so each later stage
   // can start on the previous stage's done pulse without a gap.
   always_comb begin
      state_nxt = state;
      recv_rdy  = 1'b0;
      mul_start = 1'b0;
      mul_a     = '0;
      mul_b     = '0;
      buf_wr    = 1'b0;
      case (state)
         IDLE: begin
            recv_rdy = 1'b1;
            mul_a    = ar + ac_in;
            mul_b    = br + bc_in;
            if (recv_val) begin
               mul_start = 1'b1;
               state_nxt = S0;
            end
         end
         S0: begin
            mul_a = ar_r;
            mul_b = br_r;
            if (mul_done) begin
               mul_start = 1'b1;
               state_nxt = S1;
            end
         end
         S1: begin
            mul_a = ac_r;
            mul_b = bc_r;
            if (mul_done) begin
               mul_start = 1'b1;
               state_nxt = S2;
            end
         end
         S2: begin
            if (mul_done) state_nxt = HOLD;
         end
         HOLD: begin
            buf_wr = !buf_full || send_rdy;
            if (buf_wr) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture at accept and partial-product capture at stage ends;
   // p2 is read directly from the multiplier, which holds it through HOLD.
   always_ff @(posedge clk) begin
      if (accept) begin
         ar_r <= $signed(ar);
         ac_r <= ac_in;
         br_r <= $signed(br);
         bc_r <= bc_in;
      end
      if (state == S0 && mul_done) p0_r <= $signed(mul_p);
      if (state == S1 && mul_done) p1_r <= $signed(mul_p);
   end

   // One-entry result buffer; a write while draining keeps send_val high.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_full <= 1'b0;
         cr       <= '0;
         cc       <= '0;
      end else if (buf_wr) begin
         buf_full <= 1'b1;
         cr       <= cr_nxt;
         cc       <= cc_nxt;
      end else if (buf_full && send_rdy) begin
         buf_full <= 1'b0;
      end
   end

   fp_iter_cmult_mul_unit #(
      .n (n),
      .d (d)
   ) u_mul (
      .clk   (clk),
      .reset (reset),
      .start (mul_start),
      .a     (mul_a),
      .b     (mul_b),
      .done  (mul_done),
      .p     (mul_p)
   );

endmodule

// File: tb/tb_fp_iter_cmult_buffered.sv
// Directed bench for fp_iter_cmult_buffered: a 32/16 instance for the main
// modes, backpressure and reset, and an 8/4 instance for wrap behaviour.
module tb_fp_iter_cmult_buffered;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // 32-bit instance signals
   logic        rv32 = 1'b0, rr32, sv32, sr32 = 1'b1;
   logic [1:0]  mode32 = 2'd0;
   logic [31:0] ar32 = '0, ac32 = '0, br32 = '0, bc32 = '0, cr32, cc32;

   // 8-bit instance signals
   logic        rv8 = 1'b0, rr8, sv8, sr8 = 1'b1;
   logic [1:0]  mode8 = 2'd0;
   logic [7:0]  ar8 = '0, ac8 = '0, br8 = '0, bc8 = '0, cr8, cc8;

   int n_cmp = 0;
   int n_bad = 0;

   fp_iter_cmult_buffered #(.n(32), .d(16)) dut32 (
      .clk(clk), .reset(reset), .recv_val(rv32), .recv_rdy(rr32), .mode(mode32),
      .ar(ar32), .ac(ac32), .br(br32), .bc(bc32),
      .send_val(sv32), .send_rdy(sr32), .cr(cr32), .cc(cc32));

   fp_iter_cmult_buffered #(.n(8), .d(4)) dut8 (
      .clk(clk), .reset(reset), .recv_val(rv8), .recv_rdy(rr8), .mode(mode8),
      .ar(ar8), .ac(ac8), .br(br8), .bc(bc8),
      .send_val(sv8), .send_rdy(sr8), .cr(cr8), .cc(cc8));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present an operand set until it is accepted, then scramble the inputs so
   // any late sampling of mode or operands shows up in the result.
   task automatic start32(input logic [1:0] m, input logic [31:0] a_r, input logic [31:0] a_c,
                          input logic [31:0] b_r, input logic [31:0] b_c);
      int guard = 0;
      while (!rr32 && guard < 400) begin
         tick();
         guard++;
      end
      check("recv_rdy_wait", 32'(rr32), 32'd1);
      rv32 = 1'b1; mode32 = m;
      ar32 = a_r; ac32 = a_c; br32 = b_r; bc32 = b_c;
      tick();
      rv32 = 1'b0; mode32 = ~m;
      ar32 = 32'h1234_5678; ac32 = 32'h8765_4321; br32 = 32'h0F0F_0F0F; bc32 = 32'hF0F0_F0F0;
   endtask

   // Returns the cycle index (accept cycle = 0) where send_val is first seen.
   task automatic wait_result32(output int lat);
      lat = 1;
      while (!sv32 && lat < 400) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int accepts;
      int results;
      int first_res;

      // Reset state
      reset = 1'b1;
      tick(); tick();
      check("rst_recv_rdy", 32'(rr32), 32'd1);
      check("rst_send_val", 32'(sv32), 32'd0);
      check("rst_cr", cr32, 32'd0);
      check("rst_cc", cc32, 32'd0);
      check("rst8_recv_rdy", 32'(rr8), 32'd1);
      check("rst8_send_val", 32'(sv8), 32'd0);
      reset = 1'b0;
      tick();

      // Mode 0: (1.5+2i)(0.5-1i) = 2.75-0.5i
      sr32 = 1'b1;
      start32(2'd0, 32'h0001_8000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000);
      wait_result32(lat);
      check("mul_latency", 32'(lat), 32'd98);
      check("mul_cr", cr32, 32'h0002_C000);
      check("mul_cc", cc32, 32'hFFFF_8000);
      tick();
      check("mul_drained", 32'(sv32), 32'd0);

      // Mode 1: (1.5+2i)(0.5+1i) = -1.25+2.5i
      start32(2'd1, 32'h0001_8000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000);
      wait_result32(lat);
      check("conjb_latency", 32'(lat), 32'd98);
      check("conjb_cr", cr32, 32'hFFFE_C000);
      check("conjb_cc", cc32, 32'h0002_8000);
      tick();

      // Mode 2: (1-1i)(1+1i) = 2
      start32(2'd2, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
      wait_result32(lat);
      check("conja_cr", cr32, 32'h0002_0000);
      check("conja_cc", cc32, 32'h0000_0000);
      tick();

      // Mode 3 behaves as plain multiply
      start32(2'd3, 32'h0001_8000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000);
      wait_result32(lat);
      check("mode3_cr", cr32, 32'h0002_C000);
      check("mode3_cc", cc32, 32'hFFFF_8000);
      tick();

      // Backpressure: A held in the buffer while B waits in HOLD
      sr32 = 1'b0;
      start32(2'd0, 32'h0001_8000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000);
      wait_result32(lat);
      check("bp_a_latency", 32'(lat), 32'd98);
      start32(2'd1, 32'h0001_8000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000);
      repeat (110) tick();
      check("bp_hold_send_val", 32'(sv32), 32'd1);
      check("bp_hold_recv_rdy", 32'(rr32), 32'd0);
      check("bp_hold_cr", cr32, 32'h0002_C000);
      check("bp_hold_cc", cc32, 32'hFFFF_8000);
      sr32 = 1'b1;
      tick();
      sr32 = 1'b0;
      check("bp_swap_send_val", 32'(sv32), 32'd1);
      check("bp_swap_cr", cr32, 32'hFFFE_C000);
      check("bp_swap_cc", cc32, 32'h0002_8000);
      check("bp_swap_recv_rdy", 32'(rr32), 32'd1);
      tick();
      check("bp_b_stable_cr", cr32, 32'hFFFE_C000);
      sr32 = 1'b1;
      tick();
      check("bp_b_drained", 32'(sv32), 32'd0);

      // Reset during S1 with a result buffered
      sr32 = 1'b0;
      start32(2'd0, 32'h0001_8000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000);
      wait_result32(lat);
      start32(2'd0, 32'h0001_8000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_0000);
      repeat (37) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_send_val", 32'(sv32), 32'd0);
      check("midrst_recv_rdy", 32'(rr32), 32'd1);
      check("midrst_cr", cr32, 32'd0);
      check("midrst_cc", cc32, 32'd0);
      sr32 = 1'b1;
      start32(2'd2, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
      wait_result32(lat);
      check("postrst_latency", 32'(lat), 32'd98);
      check("postrst_cr", cr32, 32'h0002_0000);
      check("postrst_cc", cc32, 32'h0000_0000);
      tick();

      // n=8, d=4: (-8)*(1-1i) wraps to 0x80 in both components;
      // recv_val held high gives one accept per 3n+2 = 26 cycles
      sr8 = 1'b1;
      rv8 = 1'b1; mode8 = 2'd1;
      ar8 = 8'h80; ac8 = 8'h00; br8 = 8'h10; bc8 = 8'h10;
      accepts = 0;
      results = 0;
      first_res = -1;
      for (int c = 0; c < 78; c++) begin
         if (rv8 && rr8) accepts++;
         if (sv8) begin
            results++;
            if (first_res < 0) first_res = c;
            check("wrap_cr", 32'(cr8), 32'h0000_0080);
            check("wrap_cc", 32'(cc8), 32'h0000_0080);
         end
         tick();
      end
      rv8 = 1'b0;
      check("wrap_accepts", 32'(accepts), 32'd3);
      check("wrap_results", 32'(results), 32'd2);
      check("wrap_latency", 32'(first_res), 32'd26);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
